// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding and port ids.
package dmem_arb_pkg;

    localparam int unsigned STATE_W = 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus bundle for dmem_arbiter.
// slave  : arbiter view (takes requests, drives the memory).
// master : environment view (requesters plus the memory).
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] adr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] adr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, adr0, wdata0,
        output gnt0, rvalid0, rdata0,
        input  req1, we1, adr1, wdata1,
        output gnt1, rvalid1, rdata1,
        output mem_adr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    modport master (
        output req0, we0, adr0, wdata0,
        input  gnt0, rvalid0, rdata0,
        output req1, we1, adr1, wdata1,
        input  gnt1, rvalid1, rdata1,
        input  mem_adr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way request picker producing a one-hot grant.
// Default: round-robin, a tie goes to the port that did not win last (ptr).
// DMEM_ARB_FIXED_PRIO_EN: port 0 always wins a tie; ptr has no effect.
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       ptr,
    output logic [1:0] grant
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Fixed priority: port 0 first.
    always_comb begin
        grant = 2'b00;
        if (req0 && !(req1 && ptr && 1'b0)) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
    end
`else
    // Round-robin: on a tie grant the port other than the last winner.
    always_comb begin
        grant = 2'b00;
        if (req0 && req1) begin
            grant = ptr ? 2'b01 : 2'b10;
        end else if (req0) begin
            grant = 2'b01;
        end else if (req1) begin
            grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-ported data memory between the MEM stage (port 0) and a
// loader/debug DMA (port 1). IDLE grants and latches one request; ACCESS
// drives the memory for one cycle and returns a registered completion.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (port 0 wins every tie).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    logic              ptr_q;
    logic              port_q;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [1:0]        grant;
    logic              accept;

    rr_arb2 u_pick (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the combinational grant and memory strobes.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.gnt0      = 1'b0;
        bus.gnt1      = 1'b0;
        bus.mem_adr   = '0;
        bus.mem_wdata = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rst && (grant != 2'b00)) begin
                    accept   = 1'b1;
                    bus.gnt0 = grant[0];
                    bus.gnt1 = grant[1];
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                if (!rst) begin
                    bus.mem_adr   = adr_q;
                    bus.mem_wdata = wdata_q;
                    bus.mem_read  = !we_q;
                    bus.mem_write = we_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request capture, fairness pointer and per-port completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= PORT1;
            port_q      <= PORT0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
        end else begin
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            if (accept) begin
                ptr_q   <= grant[1];
                port_q  <= grant[1];
                we_q    <= grant[1] ? bus.we1    : bus.we0;
                adr_q   <= grant[1] ? bus.adr1   : bus.adr0;
                wdata_q <= grant[1] ? bus.wdata1 : bus.wdata0;
            end
            if (state_q == ST_ACCESS) begin
                if (port_q == PORT0) begin
                    bus.rvalid0 <= 1'b1;
                    if (!we_q) begin
                        bus.rdata0 <= bus.mem_rdata;
                    end
                end else begin
                    bus.rvalid1 <= 1'b1;
                    if (!we_q) begin
                        bus.rdata1 <= bus.mem_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 16-word memory model.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    logic load;
    logic [31:0] mem [16];

    int errors;
    int checks;
    int n0;
    int n1;
    int nwr;
    logic exp_port;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_adr[3:0]];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[5] <= 32'h0000ABCD;
            mem[3] <= 32'h22222222;
        end else if (bus.mem_write) begin
            mem[bus.mem_adr[3:0]] <= bus.mem_wdata;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        n0 = 0;
        n1 = 0;
        nwr = 0;
        rst = 1'b1;
        load = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = '0; bus.wdata1 = '0;

        // Reset held 3 cycles with both requests up: every output stays 0.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_gnt0", 32'(bus.gnt0), 32'h0);
            chk("rst_gnt1", 32'(bus.gnt1), 32'h0);
            chk("rst_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 32'h0);
            chk("rst_rdata0", bus.rdata0, 32'h0);
            chk("rst_rdata1", bus.rdata1, 32'h0);
            chk("rst_mem_strobe", 32'({bus.mem_read, bus.mem_write}), 32'h0);
            chk("rst_mem_adr", bus.mem_adr, 32'h0);
            chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        end
        rst = 1'b0;
        load = 1'b0;
        #1;
        // First tie after reset goes to port 0.
        chk("tie_gnt0", 32'(bus.gnt0), 32'h1);
        chk("tie_gnt1", 32'(bus.gnt1), 32'h0);
        // Withdraw before the edge: nothing accepted.
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        chk("wd_gnt0", 32'(bus.gnt0), 32'h0);
        cyc();
        chk("wd_no_access", 32'({bus.mem_read, bus.mem_write}), 32'h0);

        // Single read by port 0 of word 5.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 32'd5;
        #1;
        chk("rd_gnt0", 32'(bus.gnt0), 32'h1);
        cyc();
        bus.req0 = 1'b0;
        chk("rd_mem_read", 32'(bus.mem_read), 32'h1);
        chk("rd_mem_write", 32'(bus.mem_write), 32'h0);
        chk("rd_mem_adr", bus.mem_adr, 32'd5);
        chk("rd_gnt_access", 32'({bus.gnt0, bus.gnt1}), 32'h0);
        cyc();
        chk("rd_rvalid0", 32'(bus.rvalid0), 32'h1);
        chk("rd_rdata0", bus.rdata0, 32'h0000ABCD);
        chk("rd_rvalid1", 32'(bus.rvalid1), 32'h0);
        cyc();
        chk("rd_rvalid0_pulse", 32'(bus.rvalid0), 32'h0);

        // Port 1 writes DEADBEEF to word 12 then reads it back.
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.adr1 = 32'd12; bus.wdata1 = 32'hDEADBEEF;
        #1;
        chk("wr_gnt1", 32'(bus.gnt1), 32'h1);
        cyc();
        bus.req1 = 1'b0;
        chk("wr_mem_write", 32'(bus.mem_write), 32'h1);
        chk("wr_mem_read", 32'(bus.mem_read), 32'h0);
        chk("wr_mem_adr", bus.mem_adr, 32'd12);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        cyc();
        chk("wr_rvalid1", 32'(bus.rvalid1), 32'h1);
        chk("wr_rdata1_held", bus.rdata1, 32'h0);
        chk("wr_mem_write_once", 32'(bus.mem_write), 32'h0);
        chk("wr_mem12", mem[12], 32'hDEADBEEF);
        bus.req1 = 1'b1; bus.we1 = 1'b0;
        #1;
        chk("rb_gnt1_with_rvalid", 32'(bus.gnt1), 32'h1);
        cyc();
        bus.req1 = 1'b0;
        chk("rb_mem_read", 32'(bus.mem_read), 32'h1);
        chk("rb_mem_write", 32'(bus.mem_write), 32'h0);
        cyc();
        chk("rb_rvalid1", 32'(bus.rvalid1), 32'h1);
        chk("rb_rdata1", bus.rdata1, 32'hDEADBEEF);
        chk("rb_rdata0_hold", bus.rdata0, 32'h0000ABCD);

        // Contention: both ports reading for 8 accesses.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 32'd5;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 32'd12;
        exp_port = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("ct_gnt0", 32'(bus.gnt0), 32'(!exp_port));
            chk("ct_gnt1", 32'(bus.gnt1), 32'(exp_port));
            if (bus.gnt0) n0++;
            if (bus.gnt1) n1++;
            cyc();
            chk("ct_mem_adr", bus.mem_adr, exp_port ? 32'd12 : 32'd5);
            cyc();
            chk("ct_rvalid", 32'({bus.rvalid1, bus.rvalid0}), exp_port ? 32'h2 : 32'h1);
`ifndef DMEM_ARB_FIXED_PRIO_EN
            exp_port = !exp_port;
`endif
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        chk("ct_count0", 32'(n0), 32'd8);
        chk("ct_count1", 32'(n1), 32'd0);
`else
        chk("ct_count0", 32'(n0), 32'd4);
        chk("ct_count1", 32'(n1), 32'd4);
`endif
        cyc();

        // Reset during a port 0 write to word 3 suppresses it.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.adr0 = 32'd3; bus.wdata0 = 32'h11111111;
        #1;
        chk("rm_gnt0", 32'(bus.gnt0), 32'h1);
        cyc();
        bus.req0 = 1'b0;
        rst = 1'b1;
        #1;
        chk("rm_mem_write", 32'(bus.mem_write), 32'h0);
        chk("rm_mem_read", 32'(bus.mem_read), 32'h0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rm_rvalid0", 32'(bus.rvalid0), 32'h0);
        chk("rm_mem3", mem[3], 32'h22222222);
        chk("rm_rdata0_cleared", bus.rdata0, 32'h0);

        // Port 1 raises and drops its request during port 0's ACCESS.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 32'd5;
        #1;
        chk("rq_gnt0", 32'(bus.gnt0), 32'h1);
        cyc();
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.adr1 = 32'd7; bus.wdata1 = 32'h55555555;
        #1;
        chk("rq_gnt1_access", 32'(bus.gnt1), 32'h0);
        chk("rq_mem_adr", bus.mem_adr, 32'd5);
        bus.req1 = 1'b0;
        cyc();
        chk("rq_gnt1_idle", 32'(bus.gnt1), 32'h0);
        chk("rq_rvalid0", 32'(bus.rvalid0), 32'h1);
        chk("rq_rdata0", bus.rdata0, 32'h0000ABCD);
        cyc();
        chk("rq_no_access", 32'({bus.mem_read, bus.mem_write}), 32'h0);
        chk("rq_rvalid1", 32'(bus.rvalid1), 32'h0);
        chk("rq_mem7", mem[7], 32'h0);
        nwr = nwr + 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
